// File: rtl/toggle_cover_emitter.sv
// ---------------------------------------------------------------------------
// toggle_cover_emitter
//
// Watches a WIDTH-bit signal vector and records which toggle cover points
// have been hit. Every point is reported once as an event on a valid/ready
// output stream.
//
// Cover point numbering (local):
//   bit i rising  (0->1) -> point 2*i
//   bit i falling (1->0) -> point 2*i+1
// The reported index is COVER_INDEX + local point, zero-extended to 64 bits.
//
// Ports:
//   gbl_clk      in   clock; all state changes on the rising edge
//   reset        in   synchronous, active-low reset
//   sample_en    in   enables sampling of sig and toggle detection
//   sig          in   [WIDTH-1:0] watched signal vector
//   clear        in   synchronous clear of all coverage state
//   ev_valid     out  an event is presented on ev_index
//   ev_ready     in   consumer accepts the presented event
//   ev_index     out  [63:0] absolute cover index of the presented event
//   cov_count    out  [CNT_W-1:0] number of distinct points hit so far
//   all_covered  out  every one of the 2*WIDTH points has been hit
//
// Handshake: an event transfers on a rising edge where ev_valid=1 and
// ev_ready=1. While ev_valid=1 and ev_ready=0, ev_valid and ev_index hold.
// ev_ready has no effect while ev_valid=0. A new event can be loaded every
// cycle, so a consumer holding ev_ready=1 sees one event per cycle.
// ---------------------------------------------------------------------------
module toggle_cover_emitter #(
  parameter int WIDTH       = 40,
  parameter int COVER_INDEX = 0,
  parameter int CNT_W       = $clog2(2*WIDTH+1)
) (
  input  logic             gbl_clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] sig,
  input  logic             clear,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [63:0]      ev_index,
  output logic [CNT_W-1:0] cov_count,
  output logic             all_covered
);

  localparam int NPTS   = 2 * WIDTH;
  localparam int LIDX_W = (NPTS > 1) ? $clog2(NPTS) : 1;

  // State
  logic [WIDTH-1:0]  r_prev;
  logic              r_prev_vld;
  logic [NPTS-1:0]   r_covered;
  logic [NPTS-1:0]   r_pending;
  logic              r_ev_valid;
  logic [63:0]       r_ev_index;
  logic [CNT_W-1:0]  r_cov_count;

  // Combinational helpers
  logic              w_det_en;
  logic [NPTS-1:0]   w_detect;
  logic [NPTS-1:0]   w_new_hit;
  logic [CNT_W-1:0]  w_new_cnt;
  logic              w_load;
  logic              w_take;
  logic [NPTS-1:0]   w_sel_onehot;
  logic [LIDX_W-1:0] w_sel_idx;

  // Detection needs a valid previous sample; the first enabled cycle after
  // reset or after a disabled cycle only re-arms r_prev.
  assign w_det_en = sample_en & r_prev_vld;

  always_comb begin
    w_detect = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_detect[2*i]   = w_det_en &  sig[i] & ~r_prev[i];
      w_detect[2*i+1] = w_det_en & ~sig[i] &  r_prev[i];
    end
  end

  // Only points never seen before count and get reported.
  assign w_new_hit = w_detect & ~r_covered;

  always_comb begin
    w_new_cnt = '0;
    for (int k = 0; k < NPTS; k++) begin
      w_new_cnt = w_new_cnt + CNT_W'(w_new_hit[k]);
    end
  end

  // Output register may take a new event when empty or when its current
  // event is being accepted this cycle.
  assign w_load = ~r_ev_valid | ev_ready;
  assign w_take = w_load & (|r_pending);

  // Lowest set pending bit, as a one-hot mask (two's-complement trick) and
  // as a binary index. Uses the registered pending value, so bits set at
  // this edge are not eligible until the next one.
  assign w_sel_onehot = r_pending & (~r_pending + NPTS'(1));

  always_comb begin
    w_sel_idx = '0;
    for (int k = NPTS - 1; k >= 0; k--) begin
      if (r_pending[k]) begin
        w_sel_idx = LIDX_W'(k);
      end
    end
  end

  always_ff @(posedge gbl_clk) begin
    if (!reset) begin
      r_prev      <= '0;
      r_prev_vld  <= 1'b0;
      r_covered   <= '0;
      r_pending   <= '0;
      r_ev_valid  <= 1'b0;
      r_ev_index  <= '0;
      r_cov_count <= '0;
    end else begin
      // Sample tracking is independent of clear.
      if (sample_en) begin
        r_prev     <= sig;
        r_prev_vld <= 1'b1;
      end else begin
        r_prev_vld <= 1'b0;
      end

      if (clear) begin
        // Clear wins over new hits and over a handshake in the same cycle;
        // an event presented now is dropped.
        r_covered   <= '0;
        r_pending   <= '0;
        r_cov_count <= '0;
        r_ev_valid  <= 1'b0;
      end else begin
        r_covered   <= r_covered | w_new_hit;
        r_cov_count <= r_cov_count + w_new_cnt;
        // A newly hit point was uncovered, so it can never be the bit being
        // taken out of pending this cycle.
        r_pending   <= (r_pending & ~(w_take ? w_sel_onehot : '0)) | w_new_hit;
        if (w_load) begin
          r_ev_valid <= w_take;
          if (w_take) begin
            r_ev_index <= 64'(COVER_INDEX) + 64'(w_sel_idx);
          end
        end
      end
    end
  end

  assign ev_valid    = r_ev_valid;
  assign ev_index    = r_ev_index;
  assign cov_count   = r_cov_count;
  assign all_covered = (r_cov_count == CNT_W'(NPTS));

endmodule

// File: tb/tb_toggle_cover_emitter.sv
// ---------------------------------------------------------------------------
// Testbench for toggle_cover_emitter (WIDTH=40, COVER_INDEX=100).
// Directed scenarios followed by a randomized phase; every cycle the DUT is
// compared against a behavioural model that tracks sets of covered and
// pending points and picks the smallest pending point whenever the output
// slot frees up.
// ---------------------------------------------------------------------------
module tb_toggle_cover_emitter;

  localparam int WIDTH = 40;
  localparam int NPTS  = 80;
  localparam int BASE  = 100;

  // Clock / reset
  logic gbl_clk = 1'b0;
  always #5 gbl_clk = ~gbl_clk;

  logic             reset;
  logic             sample_en;
  logic [WIDTH-1:0] sig;
  logic             clear;
  logic             ev_valid;
  logic             ev_ready;
  logic [63:0]      ev_index;
  logic [6:0]       cov_count;
  logic             all_covered;

  toggle_cover_emitter #(.WIDTH(WIDTH), .COVER_INDEX(BASE)) dut (
    .gbl_clk     (gbl_clk),
    .reset       (reset),
    .sample_en   (sample_en),
    .sig         (sig),
    .clear       (clear),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_index    (ev_index),
    .cov_count   (cov_count),
    .all_covered (all_covered)
  );

  int checks   = 0;
  int failures = 0;

  // Accepted-event scoreboard
  int acc_cnt;
  int seen[NPTS];

  // Behavioural model state
  bit [WIDTH-1:0] m_prev;
  bit             m_prev_vld;
  bit             m_cov[NPTS];
  bit             m_pend[NPTS];
  bit             m_ev_valid;
  logic [63:0]    m_ev_idx;
  int             m_count;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs now applied.
  task automatic model_step();
    int new_pts[$];
    int sel;
    if (!reset) begin
      m_prev = '0; m_prev_vld = 0; m_ev_valid = 0; m_ev_idx = '0; m_count = 0;
      for (int p = 0; p < NPTS; p++) begin m_cov[p] = 0; m_pend[p] = 0; end
    end else begin
      new_pts = {};
      if (sample_en && m_prev_vld) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (sig[i] && !m_prev[i] && !m_cov[2*i])   new_pts.push_back(2*i);
          if (!sig[i] && m_prev[i] && !m_cov[2*i+1]) new_pts.push_back(2*i+1);
        end
      end
      if (clear) begin
        for (int p = 0; p < NPTS; p++) begin m_cov[p] = 0; m_pend[p] = 0; end
        m_count = 0;
        m_ev_valid = 0;
      end else begin
        if (!m_ev_valid || ev_ready) begin
          sel = -1;
          for (int p = 0; p < NPTS; p++) if (m_pend[p] && sel < 0) sel = p;
          if (sel >= 0) begin
            m_ev_valid = 1;
            m_ev_idx = 64'(BASE + sel);
            m_pend[sel] = 0;
          end else begin
            m_ev_valid = 0;
          end
        end
        foreach (new_pts[j]) begin
          m_cov[new_pts[j]] = 1;
          m_pend[new_pts[j]] = 1;
          m_count++;
        end
      end
      if (sample_en) begin m_prev = sig; m_prev_vld = 1; end
      else m_prev_vld = 0;
    end
  endtask

  task automatic compare_model();
    check("model_ev_valid", 64'(ev_valid), 64'(m_ev_valid));
    if (m_ev_valid) check("model_ev_index", ev_index, m_ev_idx);
    check("model_cov_count", 64'(cov_count), 64'(m_count));
    check("model_all_covered", 64'(all_covered), 64'(m_count == NPTS));
  endtask

  // One clock: record an acceptance, step model, take the edge, compare #1 later.
  task automatic tick();
    if (reset && !clear && ev_valid && ev_ready) begin
      acc_cnt++;
      if (ev_index >= 64'(BASE) && ev_index < 64'(BASE + NPTS)) seen[int'(ev_index) - BASE]++;
    end
    model_step();
    @(posedge gbl_clk);
    #1;
    compare_model();
  endtask

  task automatic clear_scoreboard();
    acc_cnt = 0;
    for (int p = 0; p < NPTS; p++) seen[p] = 0;
  endtask

  initial begin
    int distinct;
    bit [WIDTH-1:0] flip;
    reset = 1'b0; sample_en = 1'b0; sig = '0; clear = 1'b0; ev_ready = 1'b0;
    clear_scoreboard();
    @(negedge gbl_clk);

    // Reset state
    tick(); tick();
    check("rst_ev_valid", 64'(ev_valid), 64'd0);
    check("rst_ev_index", ev_index, 64'd0);
    check("rst_cov_count", 64'(cov_count), 64'd0);
    check("rst_all_covered", 64'(all_covered), 64'd0);

    // Single rise on bit 3
    reset = 1'b1; sample_en = 1'b1; ev_ready = 1'b1; sig = '0;
    tick();                       // arm only
    sig[3] = 1'b1;
    tick();                       // detection edge
    check("b3_no_event_yet", 64'(ev_valid), 64'd0);
    check("b3_count", 64'(cov_count), 64'd1);
    tick();
    check("b3_valid", 64'(ev_valid), 64'd1);
    check("b3_index", ev_index, 64'd106);
    sig[3] = 1'b0;
    tick();                       // fall: new point 7
    tick();
    check("b3_fall_index", ev_index, 64'd107);
    sig[3] = 1'b1;
    tick();                       // rise again: already covered
    tick();
    check("b3_repeat_no_event", 64'(ev_valid), 64'd0);
    check("b3_repeat_count", 64'(cov_count), 64'd2);

    // Bit 0 rise and bit 39 fall together, consumer stalls
    clear = 1'b1; sig = '0; sig[39] = 1'b1;
    tick();
    clear = 1'b0; ev_ready = 1'b0;
    sig = '0; sig[0] = 1'b1;
    tick();
    tick();
    check("stall_idx0", ev_index, 64'd100);
    tick();
    check("stall_idx1", ev_index, 64'd100);
    tick();
    check("stall_idx2", ev_index, 64'd100);
    check("stall_valid", 64'(ev_valid), 64'd1);
    ev_ready = 1'b1;
    tick();
    check("stall_next_idx", ev_index, 64'd179);
    check("stall_next_valid", 64'(ev_valid), 64'd1);
    tick();
    check("stall_drained", 64'(ev_valid), 64'd0);
    check("stall_count", 64'(cov_count), 64'd2);

    // Full coverage by alternating all-ones / all-zeros
    clear = 1'b1;
    tick();
    clear = 1'b0;
    clear_scoreboard();
    sig = '1; tick();
    sig = '0; tick();
    sig = '1; tick();
    for (int k = 0; k < 100 && ev_valid; k++) tick();
    check("full_drain_done", 64'(ev_valid), 64'd0);
    check("full_events", 64'(acc_cnt), 64'd80);
    distinct = 0;
    for (int p = 0; p < NPTS; p++) if (seen[p] == 1) distinct++;
    check("full_distinct", 64'(distinct), 64'd80);
    check("full_all_covered", 64'(all_covered), 64'd1);
    check("full_count", 64'(cov_count), 64'd80);

    // Rise while sampling disabled is never reported
    clear = 1'b1; sig = '0;
    tick();
    clear = 1'b0;
    sample_en = 1'b0; sig[5] = 1'b1;
    tick();
    sample_en = 1'b1;
    tick();                       // re-arm only
    tick();
    check("dis_no_event", 64'(ev_valid), 64'd0);
    check("dis_count", 64'(cov_count), 64'd0);
    sig[5] = 1'b0;
    tick();
    tick();
    check("dis_fall_index", ev_index, 64'd111);
    tick();

    // Clear while an event is presented and five are pending
    sig = 40'h3F;
    tick();
    tick();
    check("clr_pre_valid", 64'(ev_valid), 64'd1);
    clear = 1'b1;
    tick();
    check("clr_valid", 64'(ev_valid), 64'd0);
    check("clr_count", 64'(cov_count), 64'd0);
    clear = 1'b0;
    tick();
    check("clr_stays_empty", 64'(ev_valid), 64'd0);
    sig = 40'h3E;
    tick();
    tick();
    check("clr_fall_index", ev_index, 64'd101);
    sig = 40'h3F;
    tick();
    tick();
    check("clr_rereport_valid", 64'(ev_valid), 64'd1);
    check("clr_rereport_index", ev_index, 64'd100);
    tick();

    // Reset in the middle of a drain
    sig = '0;
    tick();
    tick();
    check("mid_pre_valid", 64'(ev_valid), 64'd1);
    reset = 1'b0;
    tick();
    check("mid_rst_valid", 64'(ev_valid), 64'd0);
    check("mid_rst_index", ev_index, 64'd0);
    check("mid_rst_count", 64'(cov_count), 64'd0);
    check("mid_rst_all_covered", 64'(all_covered), 64'd0);
    reset = 1'b1; sig = 40'h80;
    tick();                       // first enabled cycle: arm only
    tick();
    check("post_rst_no_event", 64'(ev_valid), 64'd0);
    check("post_rst_count", 64'(cov_count), 64'd0);
    sig = '0;
    tick();
    tick();
    check("post_rst_fall_index", ev_index, 64'd115);

    // Randomized phase
    for (int n = 0; n < 600; n++) begin
      flip = {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
      sig       = sig ^ flip;
      sample_en = ($urandom_range(0, 9) != 0);
      ev_ready  = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 79) == 0);
      reset     = ($urandom_range(0, 149) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
